fetch_unit: RTL and testbench

- Instruction-fetch stage directly upstream of the controller. It owns the program counter (PC) and the instruction register (IR).
- Fetches an 8-bit instruction from instruction memory over a req/ack handshake and presents it as Opcode.
- Applies the controller's PC-control strobes: increment, jump-to-register and jump-to-immediate.
- Flags memory timeouts by forcing a HALT opcode into the IR.

---
 rtl/fetch_unit.sv | 125 ++++++++++++
 tb/tb_fetch_unit.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the program counter and the instruction
// register, fetches one 8-bit instruction per LoadIR over a req/ack
// handshake, and substitutes a HALT opcode when memory stops answering.
module fetch_unit #(
  parameter int              PC_W     = 8,
  parameter logic [PC_W-1:0] RESET_PC = '0,
  parameter int              TIMEOUT  = 15,
  parameter logic [7:0]      HALT_OP  = 8'hF0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            LoadIR,
  input  logic            IncPC,
  input  logic            LoadPC,
  input  logic            SelPC,
  input  logic [3:0]      ImmediateData,
  input  logic [PC_W-1:0] RegData,
  output logic            mem_req,
  output logic [PC_W-1:0] mem_addr,
  input  logic            mem_ack,
  input  logic [7:0]      mem_rdata,
  output logic [7:0]      Opcode,
  output logic            ir_valid,
  output logic            fetch_err,
  output logic [PC_W-1:0] pc
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Counter value on the last cycle we are still willing to wait for mem_ack.
  localparam logic [7:0] LAST_WAIT = 8'(TIMEOUT - 1);

  state_t          state_r;
  logic [7:0]      wait_cnt_r;
  logic [PC_W-1:0] pc_r;
  logic [PC_W-1:0] pc_next_s;
  logic [PC_W-1:0] imm_ext_s;

  assign imm_ext_s = {{(PC_W-4){1'b0}}, ImmediateData};
  assign pc        = pc_r;

  // Next PC: a jump (either source) outranks a plain increment.
  always_comb begin
    pc_next_s = pc_r;
    if (LoadPC) begin
      if (SelPC) begin
        pc_next_s = imm_ext_s;
      end else begin
        pc_next_s = RegData;
      end
    end else if (IncPC) begin
      pc_next_s = pc_r + {{(PC_W-1){1'b0}}, 1'b1};
    end else begin
      pc_next_s = pc_r;
    end
  end

  // PC register, updated in every fetch state independently of the FSM.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_r <= RESET_PC;
    end else begin
      pc_r <= pc_next_s;
    end
  end

  // Fetch FSM with registered memory request, address, IR and status flags.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r    <= IDLE;
      wait_cnt_r <= 8'd0;
      mem_req    <= 1'b0;
      mem_addr   <= {PC_W{1'b0}};
      Opcode     <= 8'h00;
      ir_valid   <= 1'b0;
      fetch_err  <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (LoadIR) begin
            // Latch the address now so later PC changes cannot disturb it.
            mem_addr   <= pc_r;
            mem_req    <= 1'b1;
            ir_valid   <= 1'b0;
            wait_cnt_r <= 8'd0;
            state_r    <= REQ;
          end else begin
            state_r <= IDLE;
          end
        end
        REQ: begin
          if (mem_ack) begin
            // An ack on the final wait cycle still counts as success.
            Opcode   <= mem_rdata;
            ir_valid <= 1'b1;
            mem_req  <= 1'b0;
            state_r  <= DONE;
          end else if (wait_cnt_r == LAST_WAIT) begin
            Opcode    <= HALT_OP;
            ir_valid  <= 1'b1;
            fetch_err <= 1'b1;
            mem_req   <= 1'b0;
            state_r   <= DONE;
          end else begin
            wait_cnt_r <= wait_cnt_r + 8'd1;
            state_r    <= REQ;
          end
        end
        DONE: begin
          // One-cycle settle; a LoadIR arriving here is intentionally dropped.
          state_r <= IDLE;
        end
        default: begin
          mem_req <= 1'b0;
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios with literal expectations plus a
// randomized run, all compared every cycle against a behavioural model.
module tb_fetch_unit;

  localparam int TO = 15;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       LoadIR = 1'b0, IncPC = 1'b0, LoadPC = 1'b0, SelPC = 1'b0;
  logic [3:0] ImmediateData = 4'h0;
  logic [7:0] RegData = 8'h00;
  logic       mem_req;
  logic [7:0] mem_addr;
  logic       mem_ack = 1'b0;
  logic [7:0] mem_rdata = 8'h00;
  logic [7:0] Opcode;
  logic       ir_valid;
  logic       fetch_err;
  logic [7:0] pc;

  int vectors = 0;
  int miscompares = 0;

  // Behavioural model state.
  logic [7:0] m_pc = 8'h00, m_op = 8'h00, m_addr = 8'h00;
  bit         m_valid = 1'b0, m_err = 1'b0;
  bit         m_busy = 1'b0;   // a fetch is outstanding
  bit         m_cool = 1'b0;   // fetch just finished, one dead cycle
  int         m_waited = 0;    // cycles spent waiting for the current fetch

  always #5 clk = ~clk;

  fetch_unit #(.PC_W(8), .RESET_PC(8'h00), .TIMEOUT(TO), .HALT_OP(8'hF0)) dut (
    .clk(clk), .reset(reset), .LoadIR(LoadIR), .IncPC(IncPC), .LoadPC(LoadPC),
    .SelPC(SelPC), .ImmediateData(ImmediateData), .RegData(RegData),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack),
    .mem_rdata(mem_rdata), .Opcode(Opcode), .ir_valid(ir_valid),
    .fetch_err(fetch_err), .pc(pc)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model advances on each rising edge, then every output is compared.
  always @(posedge clk) begin : model_cmp
    if (reset) begin
      m_pc = 8'h00; m_op = 8'h00; m_addr = 8'h00;
      m_valid = 1'b0; m_err = 1'b0; m_busy = 1'b0; m_cool = 1'b0; m_waited = 0;
    end else begin
      if (m_cool) begin
        m_cool = 1'b0;
      end else if (m_busy) begin
        m_waited = m_waited + 1;
        if (mem_ack) begin
          m_op = mem_rdata; m_valid = 1'b1; m_busy = 1'b0; m_cool = 1'b1;
        end else if (m_waited == TO) begin
          m_op = 8'hF0; m_valid = 1'b1; m_err = 1'b1; m_busy = 1'b0; m_cool = 1'b1;
        end
      end else if (LoadIR) begin
        m_busy = 1'b1; m_waited = 0; m_addr = m_pc; m_valid = 1'b0;
      end
      if (LoadPC) m_pc = SelPC ? {4'h0, ImmediateData} : RegData;
      else if (IncPC) m_pc = m_pc + 8'd1;
    end
    #1;
    check("pc", pc, m_pc);
    check("opcode", Opcode, m_op);
    check("ir_valid", ir_valid, m_valid);
    check("mem_req", mem_req, m_busy);
    check("mem_addr", mem_addr, m_addr);
    check("fetch_err", fetch_err, m_err);
  end

  task automatic cyc(input bit li, input bit inc, input bit lpc, input bit sel,
                     input logic [3:0] imm, input logic [7:0] rd,
                     input bit ack, input logic [7:0] rdata);
    @(negedge clk);
    LoadIR = li; IncPC = inc; LoadPC = lpc; SelPC = sel;
    ImmediateData = imm; RegData = rd; mem_ack = ack; mem_rdata = rdata;
    @(posedge clk);
    #2;
  endtask

  task automatic idle();
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 8'h00, 1'b0, 8'h00);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #2;
    check("rst_pc", pc, 8'h00);
    check("rst_opcode", Opcode, 8'h00);
    check("rst_valid", ir_valid, 1'b0);
    check("rst_req", mem_req, 1'b0);
    check("rst_err", fetch_err, 1'b0);
    @(negedge clk); reset = 1'b0;

    // Minimum-latency fetch at PC 0.
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 8'h00, 1'b0, 8'h00);
    check("fetch0_req", mem_req, 1'b1);
    check("fetch0_addr", mem_addr, 8'h00);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 8'h00, 1'b1, 8'h4A);
    check("fetch0_op", Opcode, 8'h4A);
    check("fetch0_valid", ir_valid, 1'b1);
    check("fetch0_req_drop", mem_req, 1'b0);
    idle();

    // PC wrap and jump-over-increment priority.
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 4'h0, 8'hFF, 1'b0, 8'h00);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 4'h0, 8'h00, 1'b0, 8'h00);
    check("pc_wrap", pc, 8'h00);
    cyc(1'b0, 1'b1, 1'b1, 1'b1, 4'h9, 8'h55, 1'b0, 8'h00);
    check("pc_imm_prio", pc, 8'h09);

    // Register jump, then fetch that times out; PC moves and LoadIR retriggers mid-wait.
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 4'h0, 8'h37, 1'b0, 8'h00);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 8'h00, 1'b0, 8'h00);
    check("jreg_addr", mem_addr, 8'h37);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 4'h0, 8'h00, 1'b0, 8'h00);
    check("addr_stable_pc", mem_addr, 8'h37);
    check("pc_inc_in_req", pc, 8'h38);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 8'h00, 1'b0, 8'h00);
    check("addr_stable_ldir", mem_addr, 8'h37);
    for (int i = 0; i < TO - 3; i++) idle();
    check("wait_req_high", mem_req, 1'b1);
    check("wait_op_held", Opcode, 8'h4A);
    idle();
    check("to_op", Opcode, 8'hF0);
    check("to_err", fetch_err, 1'b1);
    check("to_valid", ir_valid, 1'b1);
    idle();
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 8'h00, 1'b0, 8'h00);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 8'h00, 1'b1, 8'h22);
    check("after_to_op", Opcode, 8'h22);
    check("err_sticky", fetch_err, 1'b1);
    idle();

    // Reset in the middle of a wait, with a stale ack afterwards.
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 8'h00, 1'b0, 8'h00);
    @(negedge clk);
    LoadIR = 1'b0; reset = 1'b1;
    #1;
    check("async_req", mem_req, 1'b0);
    check("async_op", Opcode, 8'h00);
    check("async_valid", ir_valid, 1'b0);
    check("async_err", fetch_err, 1'b0);
    @(negedge clk);
    reset = 1'b0; mem_ack = 1'b1; mem_rdata = 8'hEE;
    @(posedge clk); #2;
    check("stale_ack_req", mem_req, 1'b0);
    check("stale_ack_op", Opcode, 8'h00);
    check("stale_ack_valid", ir_valid, 1'b0);

    // Ack on the very last allowed cycle wins over the timeout.
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 8'h00, 1'b0, 8'h00);
    for (int i = 0; i < TO - 1; i++) idle();
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 8'h00, 1'b1, 8'h13);
    check("late_ack_op", Opcode, 8'h13);
    check("late_ack_err", fetch_err, 1'b0);
    idle();

    // Randomized traffic: frequent acks first, then rare acks to provoke timeouts.
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      reset         = ($urandom_range(0, 249) == 0);
      LoadIR        = ($urandom_range(0, 9) < 3);
      IncPC         = ($urandom_range(0, 9) < 3);
      LoadPC        = ($urandom_range(0, 9) == 0);
      SelPC         = $urandom_range(0, 1);
      ImmediateData = 4'($urandom);
      RegData       = 8'($urandom);
      mem_ack       = (i < 1500) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 31) == 0);
      mem_rdata     = 8'($urandom);
    end
    @(negedge clk);
    reset = 1'b0; LoadIR = 1'b0; mem_ack = 1'b0;
    repeat (2) @(posedge clk);
    #3;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
